// File: rtl/x_uart_rx_framer.sv
// UART receive framer: SOF A5, LEN, payload, XOR check.
// Buffers a checked frame and drains it over valid/ready.
module x_uart_rx_framer #(
  parameter int p_clk_hz        = 1000000,
  parameter int p_baud          = 9600,
  parameter int p_max_len       = 16,
  parameter int p_timeout_bytes = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_pkt_valid,
  input  logic       i_pkt_ready,
  output logic [7:0] o_pkt_data,
  output logic       o_pkt_last,
  output logic [7:0] o_pkt_len,
  output logic       o_err_crc,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_err_ovf
);

  localparam int IW = (p_max_len > 1) ? $clog2(p_max_len) : 1;
  localparam int T  = p_timeout_bytes * 10 * (p_clk_hz / p_baud);
  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam logic [TW-1:0] T1   = TW'(T - 1);
  localparam logic [7:0]    MAXL = 8'(p_max_len);
  localparam logic [7:0]    SOF  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nx;
  logic [7:0]    r_xor;
  logic [7:0]    w_xor_nx;
  logic [7:0]    r_len;
  logic [7:0]    w_len_nx;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_nx;
  logic          w_tmo_hit;
  logic          w_wr;
  logic          r_err_crc;
  logic          r_err_len;
  logic          r_err_tmo;
  logic          r_err_ovf;
  logic          w_err_crc;
  logic          w_err_len;
  logic          w_err_tmo;
  logic          w_err_ovf;
  logic [7:0]    r_buf [p_max_len];

  // State, counters, checksum and registered error pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_xor     <= '0;
      r_len     <= '0;
      r_tmo     <= '0;
      r_err_crc <= 1'b0;
      r_err_len <= 1'b0;
      r_err_tmo <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_xor     <= w_xor_nx;
      r_len     <= w_len_nx;
      r_tmo     <= w_tmo_nx;
      r_err_crc <= w_err_crc;
      r_err_len <= w_err_len;
      r_err_tmo <= w_err_tmo;
      r_err_ovf <= w_err_ovf;
    end
  end

  // Payload buffer, written in PAYLOAD; contents need no reset
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_buf[r_cnt[IW-1:0]] <= i_data;
    end
  end

  // Next-state, counter and error decode; a byte beats a timeout
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_xor_nx   = r_xor;
    w_len_nx   = r_len;
    w_tmo_nx   = '0;
    w_wr       = 1'b0;
    w_err_crc  = 1'b0;
    w_err_len  = 1'b0;
    w_err_tmo  = 1'b0;
    w_err_ovf  = 1'b0;
    w_tmo_hit  = (r_tmo == T1);
    unique case (r_state)
      S_IDLE: begin
        if (i_valid && i_data == SOF) begin
          w_state_nx = S_LEN;
        end
      end
      S_LEN: begin
        if (i_valid) begin
          if (i_data == 8'd0 || i_data > MAXL) begin
            w_err_len  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_len_nx   = i_data;
            w_xor_nx   = i_data;
            w_cnt_nx   = '0;
            w_state_nx = S_PAYLOAD;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_tmo_nx = r_tmo + 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (i_valid) begin
          w_wr     = (r_cnt < MAXL);
          w_xor_nx = r_xor ^ i_data;
          if (r_cnt < MAXL) begin
            w_cnt_nx = r_cnt + 8'd1;
          end
          if (r_cnt + 8'd1 >= r_len) begin
            w_state_nx = S_CHK;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_tmo_nx = r_tmo + 1'b1;
        end
      end
      S_CHK: begin
        if (i_valid) begin
          if (i_data == r_xor) begin
            w_cnt_nx   = '0;
            w_state_nx = S_DRAIN;
          end else begin
            w_err_crc  = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo  = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_tmo_nx = r_tmo + 1'b1;
        end
      end
      S_DRAIN: begin
        w_err_ovf = i_valid;
        if (i_pkt_ready) begin
          if (r_cnt + 8'd1 >= r_len) begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign o_pkt_valid   = (r_state == S_DRAIN);
  assign o_pkt_data    = o_pkt_valid ? r_buf[r_cnt[IW-1:0]] : 8'h00;
  assign o_pkt_last    = o_pkt_valid && (r_cnt + 8'd1 == r_len);
  assign o_pkt_len     = r_len;
  assign o_err_crc     = r_err_crc;
  assign o_err_len     = r_err_len;
  assign o_err_timeout = r_err_tmo;
  assign o_err_ovf     = r_err_ovf;

endmodule

// File: doc/x_uart_rx_framer.md
X_UART_RX_FRAMER -- requirements
Module: x_uart_rx_framer

Interface
REQ-001 The block SHALL have parameter p_clk_hz, default 1000000, meaning the clock frequency in Hz.
REQ-002 The block SHALL have parameter p_baud, default 9600, meaning the line baud rate.
REQ-003 The block SHALL have parameter p_max_len, default 16, meaning the maximum payload bytes per frame (1..255).
REQ-004 The block SHALL have parameter p_timeout_bytes, default 4, meaning the inter-byte timeout in character times.
REQ-005 The block SHALL have port i_clk, input, 1, the single clock.
REQ-006 The block SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_valid, input, 1, a one-cycle strobe marking a received byte.
REQ-008 The block SHALL have port i_data, input, 8, the received byte, qualified by i_valid.
REQ-009 The block SHALL have port o_pkt_valid, output, 1, indicating that a payload byte is offered.
REQ-010 The block SHALL have port i_pkt_ready, input, 1, indicating that the sink accepts the offered byte.
REQ-011 The block SHALL have port o_pkt_data, output, 8, the payload byte.
REQ-012 The block SHALL have port o_pkt_last, output, 1, marking the final payload byte of the frame.
REQ-013 The block SHALL have port o_pkt_len, output, 8, the LEN of the frame being drained.
REQ-014 The block SHALL have ports o_err_crc, o_err_len, o_err_timeout and o_err_ovf, each an output of width 1, each a one-cycle error pulse.

Function
REQ-015 The frame format SHALL be: SOF byte 0xA5, then LEN, then LEN payload bytes, then CHK, where CHK is the XOR of LEN and all payload bytes.
REQ-016 The FSM states SHALL be IDLE, LEN, PAYLOAD, CHK and DRAIN, and only a byte with i_valid=1 SHALL advance IDLE, LEN, PAYLOAD or CHK.
REQ-017 In IDLE, byte 0xA5 SHALL go to LEN, and any other byte SHALL be discarded silently with no error.
REQ-018 In LEN, a byte with value 0 or greater than p_max_len SHALL pulse o_err_len and go to IDLE; otherwise the block SHALL store LEN, seed the running XOR with LEN, clear the byte count, and go to PAYLOAD.
REQ-019 In PAYLOAD, each byte SHALL be written to buffer[count], the count SHALL be incremented, and the byte SHALL be XORed into the running checksum; the byte for which count reaches LEN SHALL move the FSM to CHK.
REQ-020 In CHK, a byte equal to the running XOR SHALL go to DRAIN; a mismatching byte SHALL pulse o_err_crc and go to IDLE.
REQ-021 o_pkt_valid SHALL assert on the cycle after the CHK byte is accepted, which is a latency of 1 cycle.
REQ-022 In DRAIN, the block SHALL present buffer[0..LEN-1] in order, advancing on each cycle with o_pkt_valid and i_pkt_ready both high.
REQ-023 While o_pkt_valid=1 and i_pkt_ready=0, o_pkt_data, o_pkt_last and o_pkt_len SHALL hold stable.
REQ-024 o_pkt_last SHALL be 1 only with buffer[LEN-1].
REQ-025 The handshake of the last byte SHALL return the FSM to IDLE, with o_pkt_valid low on the next cycle.
REQ-026 A byte arriving in DRAIN SHALL be dropped and pulse o_err_ovf, and the drain SHALL continue unaffected.
REQ-027 The timeout limit SHALL be T = p_timeout_bytes*10*(p_clk_hz/p_baud) cycles, using integer division.
REQ-028 The timeout counter SHALL run only in LEN, PAYLOAD and CHK, and SHALL clear on entry to those states and on each i_valid.
REQ-029 When the timeout counter reaches T-1 with no i_valid, the block SHALL pulse o_err_timeout and go to IDLE.
REQ-030 If i_valid and timeout expiry coincide, the byte SHALL win, and no timeout SHALL occur.
REQ-031 All error pulses SHALL be registered, high for exactly 1 cycle, and appear on the cycle after the triggering byte or expiry.
REQ-032 The counter SHALL saturate rather than wrap, and the byte count SHALL never exceed p_max_len.
REQ-033 The buffer SHALL be p_max_len x 8 bits of flops, and its contents SHALL be don't-care outside DRAIN.

Reset
REQ-034 Assertion of i_rst_n=0 SHALL immediately force the FSM to IDLE and clear the counters, the checksum and LEN.
REQ-035 During reset, o_pkt_valid, o_pkt_last and all o_err_* outputs SHALL be 0, and o_pkt_data and o_pkt_len SHALL be 0x00.
REQ-036 Reset during any state, including mid-DRAIN, SHALL abandon the frame with no error pulse, and no partial frame SHALL be emitted after deassertion.
REQ-037 The buffer SHALL need no reset.

Verification
REQ-038 Input bytes A5 02 11 22 31 with i_pkt_ready=1 -> the bench SHALL see 11 then 22 on consecutive cycles, o_pkt_last on 22, o_pkt_len=2, and no errors.
REQ-039 Input bytes A5 02 11 22 00 -> the bench SHALL see one o_err_crc pulse, no o_pkt_valid, and the FSM in IDLE.
REQ-040 Input bytes A5 00, then separately A5 11 (with p_max_len=16) -> the bench SHALL see two o_err_len pulses and no payload.
REQ-041 Input bytes A5 01, then silence (with default parameters, T=4160) -> the bench SHALL see o_err_timeout exactly 4160 cycles after the 01 strobe; a byte at cycle 4159 SHALL prevent it.
REQ-042 Frame A5 03 01 02 03 03 with i_pkt_ready low for 5 cycles on byte 02, and a byte injected mid-drain -> the bench SHALL see 02 held for 6 cycles, one o_err_ovf pulse, and an output of 01 02 03 intact.
REQ-043 i_rst_n pulsed low after the first drained byte of a good frame -> the bench SHALL see outputs 0 immediately, and a following A5 01 7E 7F frame SHALL deliver 7E normally.
